register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 136 +++++++++++++
 tb/tb_register_file.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Architectural register file with rename state for an out-of-order core.
// Each of the 32 entries holds a value, a busy bit and the ROB tag of the
// youngest in-flight producer. x0 is hardwired: never busy and always reads 0.
//
// Parameters
//   XLEN       data width
//   ROB_IDX_W  reorder-buffer tag width
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous reset, active low (clears all state)
//   rdy                 global enable; when low, all state holds
//   flush               clears every busy bit; values are kept
//   issue_valid/_rd/_rob_index   rename of a destination at issue
//   issue_rs1/_rs2      source selects for the two combinational read ports
//   rs1_/rs2_busy, _tag, _value  read results (value is 0 while busy)
//   commit_valid/_index/_rd/_value  reorder-buffer write-back
//
// Optional feature
//   RF_BYPASS_EN  when defined, a same-cycle commit whose index matches the
//                 tag of a busy source is forwarded to that read port.
//                 When undefined, read ports show registered state only.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_IDX_W-1:0] issue_rob_index,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs1_tag,
  output logic [ROB_IDX_W-1:0] rs2_tag,
  output logic [XLEN-1:0]      rs1_value,
  output logic [XLEN-1:0]      rs2_value,
  input  logic                 commit_valid,
  input  logic [ROB_IDX_W-1:0] commit_index,
  input  logic [4:0]           commit_rd,
  input  logic [XLEN-1:0]      commit_value
);

  typedef struct packed {
    logic                 busy;
    logic [ROB_IDX_W-1:0] tag;
    logic [XLEN-1:0]      value;
  } rd_t;

  logic [XLEN-1:0]      value_q [32];
  logic [XLEN-1:0]      value_d [32];
  logic                 busy_q  [32];
  logic                 busy_d  [32];
  logic [ROB_IDX_W-1:0] tag_q   [32];
  logic [ROB_IDX_W-1:0] tag_d   [32];

  // Next-state. Entry 0 is never updated, so it stays at its reset value of
  // zero. Priority for the busy/tag pair: flush, then rename, then the
  // tag-matched commit release; a commit whose index no longer matches the
  // stored tag belongs to an older rename and must not release the entry.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      value_d[i] = value_q[i];
      busy_d[i]  = busy_q[i];
      tag_d[i]   = tag_q[i];
      if (rdy && (i != 0)) begin
        if (commit_valid && (commit_rd == 5'(i))) begin
          value_d[i] = commit_value;
        end
        if (flush) begin
          busy_d[i] = 1'b0;
        end else if (issue_valid && (issue_rd == 5'(i))) begin
          busy_d[i] = 1'b1;
          tag_d[i]  = issue_rob_index;
        end else if (commit_valid && (commit_rd == 5'(i)) &&
                     (tag_q[i] == commit_index)) begin
          busy_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= value_d[i];
        busy_q[i]  <= busy_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  // Combinational read of pre-edge state. A busy entry reads as value 0.
  function automatic rd_t read_port(input logic [4:0] sel);
    rd_t r;
    r.busy  = busy_q[sel];
    r.tag   = tag_q[sel];
    r.value = busy_q[sel] ? '0 : value_q[sel];
`ifdef RF_BYPASS_EN
    if (busy_q[sel] && commit_valid && (commit_index == tag_q[sel])) begin
      r.busy  = 1'b0;
      r.value = commit_value;
    end
`endif
    return r;
  endfunction

  rd_t rd1, rd2;

  always_comb begin
    rd1 = read_port(issue_rs1);
    rd2 = read_port(issue_rs2);
  end

  assign rs1_busy  = rd1.busy;
  assign rs1_tag   = rd1.tag;
  assign rs1_value = rd1.value;
  assign rs2_busy  = rd2.busy;
  assign rs2_tag   = rd2.tag;
  assign rs2_value = rd2.value;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file: a table of directed vectors, a few
// hand-written multi-cycle sequences (full rename + flush, asynchronous reset,
// same-cycle commit forwarding) and a randomized run checked against an
// array-based reference model of the architectural rename rules.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rdy;
  logic                 flush;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [ROB_IDX_W-1:0] issue_rob_index;
  logic [4:0]           issue_rs1;
  logic [4:0]           issue_rs2;
  logic                 rs1_busy, rs2_busy;
  logic [ROB_IDX_W-1:0] rs1_tag, rs2_tag;
  logic [XLEN-1:0]      rs1_value, rs2_value;
  logic                 commit_valid;
  logic [ROB_IDX_W-1:0] commit_index;
  logic [4:0]           commit_rd;
  logic [XLEN-1:0]      commit_value;

  register_file #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .flush           (flush),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .issue_rob_index (issue_rob_index),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .rs1_busy        (rs1_busy),
    .rs2_busy        (rs2_busy),
    .rs1_tag         (rs1_tag),
    .rs2_tag         (rs2_tag),
    .rs1_value       (rs1_value),
    .rs2_value       (rs2_value),
    .commit_valid    (commit_valid),
    .commit_index    (commit_index),
    .commit_rd       (commit_rd),
    .commit_value    (commit_value)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state as plain arrays.
  logic [XLEN-1:0]      m_val  [32];
  logic                 m_busy [32];
  logic [ROB_IDX_W-1:0] m_tag  [32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endfunction

  // Effect of one rising edge with the current inputs.
  function automatic void model_step();
    if (!rdy) return;
    if (commit_valid && commit_rd != 0) m_val[commit_rd] = commit_value;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (commit_valid && commit_rd != 0 && m_tag[commit_rd] == commit_index)
        m_busy[commit_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rob_index;
      end
    end
  endfunction

  // Expected read-port result for the current cycle.
  task automatic model_read(input logic [4:0] rs, output logic eb,
                            output logic [ROB_IDX_W-1:0] et, output logic [XLEN-1:0] ev);
    eb = m_busy[rs];
    et = m_tag[rs];
    ev = eb ? '0 : m_val[rs];
`ifdef RF_BYPASS_EN
    if (eb && commit_valid && commit_index == et) begin
      eb = 1'b0;
      ev = commit_value;
    end
`endif
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0; commit_valid = 1'b0;
    issue_rd = '0; issue_rob_index = '0; commit_rd = '0; commit_index = '0;
    commit_value = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rs1(input string nm, input logic eb, input logic [ROB_IDX_W-1:0] et,
                         input logic [XLEN-1:0] ev, input bit tagck);
    chk({nm, ".rs1_busy"}, 64'(rs1_busy), 64'(eb));
    if (tagck) chk({nm, ".rs1_tag"}, 64'(rs1_tag), 64'(et));
    chk({nm, ".rs1_value"}, 64'(rs1_value), 64'(ev));
  endtask

  task automatic chk_rs2(input string nm, input logic eb, input logic [ROB_IDX_W-1:0] et,
                         input logic [XLEN-1:0] ev, input bit tagck);
    chk({nm, ".rs2_busy"}, 64'(rs2_busy), 64'(eb));
    if (tagck) chk({nm, ".rs2_tag"}, 64'(rs2_tag), 64'(et));
    chk({nm, ".rs2_value"}, 64'(rs2_value), 64'(ev));
  endtask

  typedef struct {
    bit                   rdy;
    bit                   iv;
    logic [4:0]           ird;
    logic [ROB_IDX_W-1:0] itag;
    bit                   cv;
    logic [4:0]           crd;
    logic [ROB_IDX_W-1:0] cidx;
    logic [XLEN-1:0]      cval;
    bit                   fl;
    bit                   tagck;
    logic [4:0]           rs1;
    logic                 eb1;
    logic [ROB_IDX_W-1:0] et1;
    logic [XLEN-1:0]      ev1;
    logic [4:0]           rs2;
    logic                 eb2;
    logic [ROB_IDX_W-1:0] et2;
    logic [XLEN-1:0]      ev2;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    logic                 eb1, eb2;
    logic [ROB_IDX_W-1:0] et1, et2;
    logic [XLEN-1:0]      ev1, ev2;

    // Each row: inputs for one edge, then expected reads after that edge.
    //          rdy iv ird itag cv crd cidx cval          fl tck rs1 b t  v             rs2 b t  v
    vecs[0] = '{1, 1, 5, 12, 0, 0, 0,  32'h0,          0, 1,  5, 1, 12, 32'h0,        0, 0, 0,  32'h0};
    vecs[1] = '{1, 0, 0, 0,  1, 5, 12, 32'hDEADBEEF,   0, 1,  5, 0, 12, 32'hDEADBEEF, 5, 0, 12, 32'hDEADBEEF};
    vecs[2] = '{1, 1, 7, 3,  0, 0, 0,  32'h0,          0, 1,  7, 1, 3,  32'h0,        5, 0, 12, 32'hDEADBEEF};
    vecs[3] = '{1, 1, 7, 9,  0, 0, 0,  32'h0,          0, 1,  7, 1, 9,  32'h0,        7, 1, 9,  32'h0};
    vecs[4] = '{1, 0, 0, 0,  1, 7, 3,  32'h11,         0, 1,  7, 1, 9,  32'h0,        0, 0, 0,  32'h0};
    vecs[5] = '{1, 1, 4, 20, 1, 4, 20, 32'h55,         0, 1,  4, 1, 20, 32'h0,        7, 1, 9,  32'h0};
    vecs[6] = '{1, 0, 0, 0,  0, 0, 0,  32'h0,          1, 0,  7, 0, 0,  32'h11,       4, 0, 0,  32'h55};
    vecs[7] = '{1, 1, 0, 5,  1, 0, 0,  32'hFFFF,       0, 1,  0, 0, 0,  32'h0,        5, 0, 12, 32'hDEADBEEF};
    vecs[8] = '{0, 1, 9, 1,  1, 5, 0,  32'h1234,       1, 1,  9, 0, 0,  32'h0,        5, 0, 12, 32'hDEADBEEF};
    vecs[9] = '{1, 1, 9, 1,  0, 0, 0,  32'h0,          0, 1,  9, 1, 1,  32'h0,        0, 0, 0,  32'h0};

    idle();
    issue_rs1 = '0; issue_rs2 = '0;
    rst = 1'b0;
    model_reset();
    #12;
    chk_rs1("reset", 1'b0, '0, '0, 1);
    issue_rs1 = 5'd5; issue_rs2 = 5'd31;
    #1;
    chk_rs1("reset_x5", 1'b0, '0, '0, 1);
    chk_rs2("reset_x31", 1'b0, '0, '0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int v = 0; v < NV; v++) begin
      rdy = vecs[v].rdy; flush = vecs[v].fl;
      issue_valid = vecs[v].iv; issue_rd = vecs[v].ird; issue_rob_index = vecs[v].itag;
      commit_valid = vecs[v].cv; commit_rd = vecs[v].crd; commit_index = vecs[v].cidx;
      commit_value = vecs[v].cval;
      tick();
      idle();
      issue_rs1 = vecs[v].rs1; issue_rs2 = vecs[v].rs2;
      #1;
      chk_rs1($sformatf("vec%0d", v), vecs[v].eb1, vecs[v].et1, vecs[v].ev1, vecs[v].tagck);
      chk_rs2($sformatf("vec%0d", v), vecs[v].eb2, vecs[v].et2, vecs[v].ev2, vecs[v].tagck);
    end

    // Rename x1..x31, then flush with a commit to x2 and an ignored issue.
    for (int i = 1; i < 32; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i); issue_rob_index = ROB_IDX_W'(i);
      tick();
    end
    idle();
    issue_rs1 = 5'd31; issue_rs2 = 5'd2;
    #1;
    chk_rs1("renamed_x31", 1'b1, 6'd31, '0, 1);
    chk_rs2("renamed_x2", 1'b1, 6'd2, '0, 1);
    flush = 1'b1;
    commit_valid = 1'b1; commit_rd = 5'd2; commit_index = 6'd63; commit_value = 32'h77;
    issue_valid = 1'b1; issue_rd = 5'd3; issue_rob_index = 6'd50;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      issue_rs1 = 5'(i);
      #1;
      chk($sformatf("flush_busy_x%0d", i), 64'(rs1_busy), 64'(0));
    end
    issue_rs1 = 5'd2; issue_rs2 = 5'd5;
    #1;
    chk_rs1("flush_x2", 1'b0, '0, 32'h77, 0);
    chk_rs2("flush_x5", 1'b0, '0, 32'hDEADBEEF, 0);

    // Asynchronous reset mid-operation leaves no pending rename.
    issue_valid = 1'b1; issue_rd = 5'd10; issue_rob_index = 6'd7;
    tick();
    idle();
    issue_rs1 = 5'd10;
    #1;
    chk_rs1("pre_reset_x10", 1'b1, 6'd7, '0, 1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk_rs1("async_reset_x10", 1'b0, '0, '0, 1);
    chk_rs2("async_reset_x5", 1'b0, '0, '0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_rs1("post_reset_x10", 1'b0, '0, '0, 1);

    // Same-cycle commit seen on a read port.
    issue_valid = 1'b1; issue_rd = 5'd6; issue_rob_index = 6'd40;
    tick();
    idle();
    issue_rs2 = 5'd6;
    commit_valid = 1'b1; commit_rd = 5'd6; commit_index = 6'd40; commit_value = 32'hABCD;
    #1;
`ifdef RF_BYPASS_EN
    chk_rs2("bypass_same_cycle", 1'b0, 6'd40, 32'hABCD, 1);
`else
    chk_rs2("no_bypass_same_cycle", 1'b1, 6'd40, '0, 1);
`endif
    tick();
    idle();
    #1;
    chk_rs2("commit_next_cycle", 1'b0, 6'd40, 32'hABCD, 1);

    // Randomized run against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] rd_c;
      rdy          = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 31) == 0);
      issue_valid  = 1'($urandom);
      issue_rd     = 5'($urandom_range(0, 7));
      issue_rob_index = ROB_IDX_W'($urandom);
      commit_valid = 1'($urandom);
      rd_c         = 5'($urandom_range(0, 7));
      commit_rd    = rd_c;
      commit_index = ($urandom_range(0, 2) != 0) ? m_tag[rd_c] : ROB_IDX_W'($urandom);
      commit_value = $urandom;
      issue_rs1    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      issue_rs2    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      #1;
      model_read(issue_rs1, eb1, et1, ev1);
      model_read(issue_rs2, eb2, et2, ev2);
      chk_rs1($sformatf("rand%0d", n), eb1, et1, ev1, 1);
      chk_rs2($sformatf("rand%0d", n), eb2, et2, ev2, 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
